// File: rtl/systolic_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_feeder
// Description : Control and operand sequencer for a 3x3 systolic array.
//               Preloads nine weights, streams four passes of skewed row
//               operands, steers the result / C-register demux selects and
//               drains the array, with a start/busy/done host handshake.
// Ports       : i_clk, i_rst_n            clock, async active-low reset
//               i_start                   begin sequence (IDLE only)
//               i_wr_en/i_wr_addr/i_wr_data  operand/weight load (IDLE only)
//                 addr 0..8  -> B11..B33, addr 9+3p+(k-1) -> pass p row k
//               o_busy, o_done            handshake
//               o_en_reg_B, o_B11..o_B33  weight enables and values
//               o_en_reg_A, o_en_reg_Acc  row register / accumulator enable
//               o_row1_in..o_row3_in      skewed row operands
//               o_sel_en_demux_result, o_sel_en_demux_c_reg, o_input_demux_c_reg
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_feeder #(
  parameter int DATA_W        = 8,
  parameter int PASS_LEN      = 5,
  parameter int B_LOAD_CYCLES = 2,
  parameter int DRAIN_CYCLES  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_wr_en,
  input  logic [4:0]        i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [8:0]        o_en_reg_B,
  output logic [DATA_W-1:0] o_B11, o_B12, o_B13,
  output logic [DATA_W-1:0] o_B21, o_B22, o_B23,
  output logic [DATA_W-1:0] o_B31, o_B32, o_B33,
  output logic              o_en_reg_A,
  output logic              o_en_reg_Acc,
  output logic [DATA_W-1:0] o_row1_in,
  output logic [DATA_W-1:0] o_row2_in,
  output logic [DATA_W-1:0] o_row3_in,
  output logic [1:0]        o_sel_en_demux_result,
  output logic [1:0]        o_sel_en_demux_c_reg,
  output logic              o_input_demux_c_reg
);

  localparam logic [4:0] c_LOAD_LAST  = 5'(B_LOAD_CYCLES - 1);
  localparam logic [4:0] c_DRAIN_LAST = 5'(DRAIN_CYCLES - 1);
  localparam logic [2:0] c_LAST_PHASE = 3'(PASS_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [1:0]        r_pass;
  logic [2:0]        r_phase;
  logic [DATA_W-1:0] r_wgt [0:8];
  logic [DATA_W-1:0] r_op  [0:11];

  logic              r_busy, r_done, r_en_a, r_demux;
  logic [8:0]        r_en_b;
  logic [DATA_W-1:0] r_row1, r_row2, r_row3;
  logic [1:0]        r_sel;

  // Pass/phase of the cycle about to be entered. Outside STREAM this is the
  // first stream cycle, so the LOAD_B -> STREAM edge reuses the same logic.
  logic [1:0]        w_nx_pass;
  logic [2:0]        w_nx_phase;
  logic [3:0]        w_base;
  logic [DATA_W-1:0] w_row1, w_row2, w_row3;
  logic [1:0]        w_sel;
  logic [3:0]        w_wr_idx;
  logic              w_last_stream;

  always_comb begin
    w_nx_pass  = 2'd0;
    w_nx_phase = 3'd0;
    if (r_state == S_STREAM) begin
      if (r_phase == c_LAST_PHASE) begin
        w_nx_pass  = r_pass + 2'd1;
        w_nx_phase = 3'd0;
      end else begin
        w_nx_pass  = r_pass;
        w_nx_phase = r_phase + 3'd1;
      end
    end
    // Operand base index = 3 * pass
    w_base = {2'b00, w_nx_pass} + {1'b0, w_nx_pass, 1'b0};
    // Row k is live for phases k-1..k+1, giving the one-cycle diagonal skew
    w_row1 = (w_nx_phase <= 3'd2) ? r_op[w_base] : '0;
    w_row2 = (w_nx_phase >= 3'd1 && w_nx_phase <= 3'd3) ? r_op[w_base + 4'd1] : '0;
    w_row3 = (w_nx_phase >= 3'd2 && w_nx_phase <= 3'd4) ? r_op[w_base + 4'd2] : '0;
    // Select lags the start of a new pass by one cycle so the previous pass's
    // last result still lands in its own C register.
    if (w_nx_phase != 3'd0)
      w_sel = w_nx_pass;
    else if (w_nx_pass == 2'd0)
      w_sel = 2'd0;
    else
      w_sel = w_nx_pass - 2'd1;
  end

  // addr 9..20 maps to 0..11 using only the low nibble (modulo-16 wrap)
  assign w_wr_idx      = i_wr_addr[3:0] - 4'd9;
  assign w_last_stream = (r_pass == 2'd3) && (r_phase == c_LAST_PHASE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_phase <= '0;
      for (int i = 0; i < 9; i++)  r_wgt[i] <= '0;
      for (int i = 0; i < 12; i++) r_op[i]  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_en_b  <= '0;
      r_en_a  <= 1'b0;
      r_row1  <= '0;
      r_row2  <= '0;
      r_row3  <= '0;
      r_sel   <= '0;
      r_demux <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LOAD_B;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_en_b  <= 9'h1FF;
            r_en_a  <= 1'b0;
            r_sel   <= 2'd0;
            r_demux <= 1'b1;
          end else if (i_wr_en) begin
            if (i_wr_addr < 5'd9)
              r_wgt[i_wr_addr[3:0]] <= i_wr_data;
            else if (i_wr_addr < 5'd21)
              r_op[w_wr_idx] <= i_wr_data;
          end
        end
        S_LOAD_B: begin
          if (r_cnt == c_LOAD_LAST) begin
            r_state <= S_STREAM;
            r_pass  <= w_nx_pass;
            r_phase <= w_nx_phase;
            r_en_b  <= '0;
            r_en_a  <= 1'b1;
            r_row1  <= w_row1;
            r_row2  <= w_row2;
            r_row3  <= w_row3;
            r_sel   <= w_sel;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_STREAM: begin
          if (w_last_stream) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
            r_row1  <= '0;
            r_row2  <= '0;
            r_row3  <= '0;
            r_sel   <= 2'd3;
          end else begin
            r_pass  <= w_nx_pass;
            r_phase <= w_nx_phase;
            r_row1  <= w_row1;
            r_row2  <= w_row2;
            r_row3  <= w_row3;
            r_sel   <= w_sel;
          end
        end
        S_DRAIN: begin
          if (r_cnt == c_DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_en_a  <= 1'b0;
            r_demux <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_en_reg_B            = r_en_b;
  assign o_en_reg_A            = r_en_a;
  assign o_en_reg_Acc          = 1'b0;
  assign o_row1_in             = r_row1;
  assign o_row2_in             = r_row2;
  assign o_row3_in             = r_row3;
  assign o_sel_en_demux_result = r_sel;
  assign o_sel_en_demux_c_reg  = r_sel;
  assign o_input_demux_c_reg   = r_demux;
  assign o_B11 = r_wgt[0];
  assign o_B12 = r_wgt[1];
  assign o_B13 = r_wgt[2];
  assign o_B21 = r_wgt[3];
  assign o_B22 = r_wgt[4];
  assign o_B23 = r_wgt[5];
  assign o_B31 = r_wgt[6];
  assign o_B32 = r_wgt[7];
  assign o_B33 = r_wgt[8];

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_feeder
// Description : Directed self-checking bench for systolic_array_feeder.
//               Expected rows/selects are hand-computed tables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, en_reg_A, en_reg_Acc, input_demux_c_reg;
  logic [8:0] en_reg_B;
  logic [7:0] B11, B12, B13, B21, B22, B23, B31, B32, B33;
  logic [7:0] row1_in, row2_in, row3_in;
  logic [1:0] sel_res, sel_creg;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed row outputs: [pass parity][row][phase]
  int row_tab [0:1][0:2][0:4] = '{
    '{'{1,1,1,0,0}, '{0,2,2,2,0}, '{0,0,3,3,3}},
    '{'{2,2,2,0,0}, '{0,3,3,3,0}, '{0,0,4,4,4}}
  };
  int sel_tab [0:19] = '{0,0,0,0,0, 0,1,1,1,1, 1,2,2,2,2, 2,3,3,3,3};
  int wgt_tab [0:8]  = '{1,2,3,1,2,3,1,2,3};
  int op_tab  [0:11] = '{1,2,3,2,3,4,1,2,3,2,3,4};

  systolic_array_feeder dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_start               (start),
    .i_wr_en               (wr_en),
    .i_wr_addr             (wr_addr),
    .i_wr_data             (wr_data),
    .o_busy                (busy),
    .o_done                (done),
    .o_en_reg_B            (en_reg_B),
    .o_B11(B11), .o_B12(B12), .o_B13(B13),
    .o_B21(B21), .o_B22(B22), .o_B23(B23),
    .o_B31(B31), .o_B32(B32), .o_B33(B33),
    .o_en_reg_A            (en_reg_A),
    .o_en_reg_Acc          (en_reg_Acc),
    .o_row1_in             (row1_in),
    .o_row2_in             (row2_in),
    .o_row3_in             (row3_in),
    .o_sel_en_demux_result (sel_res),
    .o_sel_en_demux_c_reg  (sel_creg),
    .o_input_demux_c_reg   (input_demux_c_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, " busy"},  busy, 0);
    chk({pfx, " done"},  done, 0);
    chk({pfx, " enB"},   en_reg_B, 0);
    chk({pfx, " enA"},   en_reg_A, 0);
    chk({pfx, " enAcc"}, en_reg_Acc, 0);
    chk({pfx, " rows"},  {row1_in, row2_in, row3_in}, 0);
    chk({pfx, " sels"},  {sel_res, sel_creg}, 0);
    chk({pfx, " demux"}, input_demux_c_reg, 1);
    chk({pfx, " B"},     {B11 | B12 | B13 | B21 | B22 | B23 | B31 | B32 | B33}, 0);
  endtask

  // Checks cycle n (n=1 is the cycle after the start edge). Caller has
  // already driven start=1 before the call.
  task automatic run_seq(input bit noise);
    int done_cnt = 0;
    int enb_cnt  = 0;
    for (int n = 1; n <= 26; n++) begin
      int s, p, c;
      int e1, e2, e3, es;
      tick();
      if (n == 1) begin start = 1'b0; wr_en = 1'b0; end
      e1 = 0; e2 = 0; e3 = 0; es = 0;
      if (n >= 3 && n <= 22) begin
        s = n - 3; p = s / 5; c = s % 5;
        e1 = row_tab[p % 2][0][c];
        e2 = row_tab[p % 2][1][c];
        e3 = row_tab[p % 2][2][c];
        es = sel_tab[s];
      end else if (n >= 23) begin
        es = 3;
      end
      if (done) done_cnt++;
      if (en_reg_B == 9'h1FF) enb_cnt++;
      chk($sformatf("n%0d busy", n),  busy, (n <= 25) ? 1 : 0);
      chk($sformatf("n%0d done", n),  done, (n == 25) ? 1 : 0);
      chk($sformatf("n%0d enB", n),   en_reg_B, (n <= 2) ? 9'h1FF : 9'h0);
      chk($sformatf("n%0d enA", n),   en_reg_A, (n >= 3 && n <= 24) ? 1 : 0);
      chk($sformatf("n%0d enAcc", n), en_reg_Acc, 0);
      chk($sformatf("n%0d demux", n), input_demux_c_reg, (n >= 25) ? 0 : 1);
      chk($sformatf("n%0d row1", n),  row1_in, e1);
      chk($sformatf("n%0d row2", n),  row2_in, e2);
      chk($sformatf("n%0d row3", n),  row3_in, e3);
      chk($sformatf("n%0d selc", n),  sel_creg, sel_res);
      if (n <= 24) chk($sformatf("n%0d sel", n), sel_res, es);
      if (noise) begin
        if (n == 9)  start = 1'b1;
        if (n == 10) start = 1'b0;
        if (n == 11) begin wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'd9; end
        if (n == 12) wr_en = 1'b0;
      end
    end
    chk("done pulses", done_cnt, 1);
    chk("enB cycles", enb_cnt, 2);
    chk("B11 stable", B11, 1);
    chk("B12 stable", B12, 2);
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("post-rst");

    for (int i = 0; i < 9; i++)  wr(5'(i), 8'(wgt_tab[i]));
    for (int i = 0; i < 12; i++) wr(5'(9 + i), 8'(op_tab[i]));
    wr(5'd25, 8'd99);
    chk("B11", B11, 1); chk("B12", B12, 2); chk("B13", B13, 3);
    chk("B21", B21, 1); chk("B22", B22, 2); chk("B23", B23, 3);
    chk("B31", B31, 1); chk("B32", B32, 2); chk("B33", B33, 3);

    // First run: write on the start edge must be dropped
    start = 1'b1; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'd55;
    run_seq(1'b1);
    // Back-to-back: start on the first IDLE cycle after done
    start = 1'b1;
    run_seq(1'b0);
    tick();
    chk("idle demux", input_demux_c_reg, 0);
    chk("idle busy", busy, 0);

    // Abort with reset at stream cycle s=7
    start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      start = 1'b0;
    end
    chk("s7 row1", row1_in, 2);
    chk("s7 row2", row2_in, 3);
    chk("s7 row3", row3_in, 4);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async-rst");
    seen_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("no done after abort", seen_done, 0);
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("after-abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
